// File: rtl/mac_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arb_pkg
//  Description : Shared types and defaults for the MAC TX frame arbiter:
//                data geometry, default source count, drop-counter width,
//                arbiter state encoding and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_tx_arb_pkg;

    // Data geometry of one stream beat
    localparam int N_SYMBOLS  = 8;
    localparam int W_SYMBOL   = 8;

    // Arbiter defaults
    localparam int N_TX_SRC   = 2;
    localparam int W_DROP_CNT = 16;

    // One-hot arbiter state
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_FWD   = 3'b010,
        ST_FLUSH = 3'b100
    } arb_state_t;

    // Width of an index into n items, never below one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tx_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_rr_pick
//  Description : Combinational one-hot picker. Optional strict priority for
//                request 0, otherwise a round-robin search upward from the
//                pointer, wrapping modulo N_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_rr_pick #(
    parameter int N_REQ = 2,
    parameter int W_IDX = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [W_IDX-1:0] ptr_i,
    input  logic             prio_en_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [W_IDX-1:0] gnt_idx_o
);

    logic w_found;
    int   w_k;

    // First requester at or after the pointer wins, unless request 0 has priority
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_k       = 0;
        if (prio_en_i && req_i[0]) begin
            gnt_oh_o[0] = 1'b1;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                w_k = (int'(ptr_i) + i) % N_REQ;
                if (!w_found && req_i[w_k]) begin
                    w_found       = 1'b1;
                    gnt_oh_o[w_k] = 1'b1;
                    gnt_idx_o     = W_IDX'(w_k);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mac_tx_arb
//  Description : Frame-granular arbiter sharing the MAC TX stream between
//                N_SRC sources. Grant is held for a whole frame; a source that
//                underruns mid-frame has the rest of its frame drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_arb
    import mac_tx_arb_pkg::*;
#(
    parameter int N_SRC   = N_TX_SRC,
    parameter int P_PRIO0 = 1,
    parameter int W_CNT   = W_DROP_CNT
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_clk_en,
    input  logic [N_SRC-1:0]                    s_tvalid,
    input  logic [N_SRC*N_SYMBOLS*W_SYMBOL-1:0] s_tdata,
    input  logic [N_SRC*N_SYMBOLS-1:0]          s_tkeep,
    input  logic [N_SRC-1:0]                    s_tlast,
    output logic [N_SRC-1:0]                    s_tready,
    output logic                                m_tvalid,
    output logic [N_SYMBOLS*W_SYMBOL-1:0]       m_tdata,
    output logic [N_SYMBOLS-1:0]                m_tkeep,
    output logic                                m_tlast,
    input  logic                                m_tready,
    output logic [N_SRC-1:0]                    o_grant,
    output logic                                o_busy,
    output logic                                o_underrun,
    output logic [W_CNT-1:0]                    o_drop_cnt
);

    localparam int W_IDX  = idx_width(N_SRC);
    localparam int W_BEAT = N_SYMBOLS * W_SYMBOL;

    arb_state_t         q_state;
    logic [N_SRC-1:0]   q_grant;
    logic [W_IDX-1:0]   q_gidx;
    logic [W_IDX-1:0]   q_rr_ptr;
    logic [W_CNT-1:0]   q_drop_cnt;

    logic [N_SRC-1:0]   w_pick_oh;
    logic [W_IDX-1:0]   w_pick_idx;
    logic [W_IDX-1:0]   w_rr_next;
    logic               w_fwd;
    logic               w_flush;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [W_BEAT-1:0]  w_sel_data;
    logic [N_SYMBOLS-1:0] w_sel_keep;
    logic               w_underrun;

    mac_tx_rr_pick #(
        .N_REQ (N_SRC),
        .W_IDX (W_IDX)
    ) u_pick (
        .req_i     (s_tvalid),
        .ptr_i     (q_rr_ptr),
        .prio_en_i (P_PRIO0 != 0),
        .gnt_oh_o  (w_pick_oh),
        .gnt_idx_o (w_pick_idx)
    );

    assign w_rr_next   = (w_pick_idx == W_IDX'(N_SRC - 1)) ? '0 : w_pick_idx + 1'b1;

    assign w_fwd       = (q_state == ST_FWD);
    assign w_flush     = (q_state == ST_FLUSH);

    // Selected source lane, addressed by the registered grant index
    assign w_sel_valid = s_tvalid[q_gidx];
    assign w_sel_last  = s_tlast[q_gidx];
    assign w_sel_data  = s_tdata[int'(q_gidx) * W_BEAT +: W_BEAT];
    assign w_sel_keep  = s_tkeep[int'(q_gidx) * N_SYMBOLS +: N_SYMBOLS];

    // MAC ready with no data from the owner: the MAC aborts this frame itself
    assign w_underrun  = i_clk_en & w_fwd & m_tready & ~w_sel_valid;

    // Arbitration FSM, grant/pointer registers and saturating drop counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            q_state    <= ST_IDLE;
            q_grant    <= '0;
            q_gidx     <= '0;
            q_rr_ptr   <= '0;
            q_drop_cnt <= '0;
        end else if (i_clk_en) begin
            unique case (q_state)
                ST_IDLE: begin
                    if (|s_tvalid) begin
                        q_state  <= ST_FWD;
                        q_grant  <= w_pick_oh;
                        q_gidx   <= w_pick_idx;
                        q_rr_ptr <= w_rr_next;
                    end
                end
                ST_FWD: begin
                    if (w_sel_valid && m_tready && w_sel_last) begin
                        q_state <= ST_IDLE;
                        q_grant <= '0;
                    end else if (w_underrun) begin
                        q_state <= ST_FLUSH;
                        if (q_drop_cnt != '1) begin
                            q_drop_cnt <= q_drop_cnt + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_sel_valid && w_sel_last) begin
                        q_state <= ST_IDLE;
                        q_grant <= '0;
                    end
                end
                default: begin
                    q_state <= ST_IDLE;
                    q_grant <= '0;
                end
            endcase
        end
    end

    // Zero-latency pass-through while forwarding; quiet otherwise
    assign m_tvalid   = w_fwd & w_sel_valid;
    assign m_tdata    = w_fwd ? w_sel_data : '0;
    assign m_tkeep    = w_fwd ? w_sel_keep : '0;
    assign m_tlast    = w_fwd & w_sel_last;

    // Only the owner sees ready; FLUSH accepts unconditionally to discard beats
    assign s_tready   = (i_clk_en && ((w_fwd && m_tready) || w_flush)) ? q_grant : '0;

    assign o_grant    = q_grant;
    assign o_busy     = w_fwd | w_flush;
    assign o_underrun = w_underrun;
    assign o_drop_cnt = q_drop_cnt;

endmodule
`default_nettype wire

// File: doc/mac_tx_arb.md
# mac_tx_arb

Frame-granular arbiter that shares the single MAC TX AXI-Stream input (`mac_tx_ctrl` slave port) between `N_SRC` upstream frame sources, e.g. a pause/control-frame generator and the user data path.
- Once a source is granted, the arbiter holds the grant for the whole frame. It only re-arbitrates after the `tlast` beat is accepted.
- If a source underruns mid-frame, the arbiter drains and discards the remainder of that frame, so the stream stays frame-aligned.
- It sits directly in front of `mac_tx_ctrl`, in the same `i_clk`/`i_clk_en` domain.

## Interface
- `N_SRC`, 2: number of upstream sources (2..8).
- `P_PRIO0`, 1: 1 = source 0 has strict priority over the rest; 0 = pure round-robin.
- `W_CNT`, 16: width of the drop counter.
- Data geometry `N_SYMBOLS`/`W_SYMBOL` comes from `cmn_params`.

Ports:
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  asynchronous active-low reset.
- `i_clk_en`  in  1  clock enable. All state advances only when high.
- `s_tvalid`  in  `N_SRC`  per-source valid.
- `s_tdata`  in  `N_SRC`×`N_SYMBOLS`×`W_SYMBOL`  per-source data.
- `s_tkeep`  in  `N_SRC`×`N_SYMBOLS`  per-source keep.
- `s_tlast`  in  `N_SRC`  per-source last.
- `s_tready`  out  `N_SRC`  per-source ready.
- `m_tvalid`, `m_tdata`, `m_tkeep`, `m_tlast`  out  1 / `N_SYMBOLS`×`W_SYMBOL` / `N_SYMBOLS` / 1  stream to the MAC.
- `m_tready`  in  1  MAC ready.
- `o_grant`  out  `N_SRC`  one-hot current owner; 0 when idle.
- `o_busy`  out  1  high in FWD or FLUSH.
- `o_underrun`  out  1  one-cycle pulse when an underrun is detected.
- `o_drop_cnt`  out  `W_CNT`  saturating count of aborted frames.

## Operation
States (one-hot `arb_state_t`): `ST_IDLE`, `ST_FWD`, `ST_FLUSH`.

- **ST_IDLE**
  - `m_tvalid`=0 and `s_tready`=0.
  - If any `s_tvalid` is high, pick a winner and register it into `q_grant`, then go to FWD.
  - Selection with `P_PRIO0`=1: source 0 wins if valid. Otherwise round-robin, searching upward from `q_rr_ptr` and wrapping modulo `N_SRC`.
  - On grant, `q_rr_ptr` ← winner+1 (wraps at `N_SRC`).
- **ST_FWD** (pure combinational pass-through, zero added latency)
  - `m_*` = `s_*[g]`.
  - `s_tready[g]` = `m_tready`; all other readies are 0.
  - `s_tvalid[g]`&`m_tready`&`s_tlast[g]` → IDLE, with `q_grant` cleared.
  - Underrun: `m_tready`&!`s_tvalid[g]` → FLUSH. Pulse `o_underrun` and increment `o_drop_cnt`, saturating at all-ones. The MAC aborts the frame on this cycle by itself.
- **ST_FLUSH**
  - `m_tvalid`=0 and `s_tready[g]`=1; beats are discarded.
  - `s_tvalid[g]`&`s_tlast[g]` → IDLE.
- Grant never changes mid-frame, even if a higher-priority source asserts valid.

## Timing
- Reset (async assert, synchronous deassert in the parent):
  - state=IDLE, `q_grant`=0, `q_rr_ptr`=0, `o_drop_cnt`=0.
  - All outputs 0, including `s_tready` and `m_tvalid`.
- Grant latency: the first valid is seen in IDLE on enabled cycle N. FWD and forwarding begin at enabled cycle N+1.
- After a `tlast` handshake there is at least one IDLE cycle before the next grant. That cycle is covered by the MAC IFG, during which `m_tready`=0.
- `i_clk_en`=0: registers hold, and `s_tready`/`o_underrun` are forced to 0, mirroring the MAC's ready gating.
- FWD with `m_tready`=0 is not an underrun; `s_tvalid` may drop freely while the MAC is not ready.
- Simultaneous `tlast` accept and new requests: the transition to IDLE wins, and the new requests are arbitrated on the next cycle.
- Underrun on the same cycle the source would have sent `tlast` is still an underrun. The flush ends on the source's next `tlast`.
- Reset mid-frame returns to IDLE immediately. A partially sent source frame is not tracked; its remaining beats are treated as a new frame.

## Structure
- Add to `mac_params`: `N_TX_SRC` default, `arb_state_t` typedef, `W_DROP_CNT`.
- Sub-module `mac_tx_rr_pick`: combinational one-hot round-robin picker.
  - Inputs: request vector, pointer, priority enable.
  - Outputs: one-hot winner and winner index.
- The FSM, pass-through mux and counter live in `mac_tx_arb`.

## Test plan
- **Single frame:** src1 sends a 16-beat frame, MAC always ready.
  - `o_grant`=2'b10 one cycle after the first valid.
  - 16 beats appear on `m_*` bit-exact, then `o_grant`=0.
- **Priority:** `P_PRIO0`=1 with both sources valid in IDLE.
  - src0 is granted.
  - src0 asserting valid during a src1 frame does not preempt src1.
- **Round-robin:** `P_PRIO0`=0, both sources continuously valid, 4 frames each.
  - Grants alternate 0,1,0,1…
  - No beats are interleaved between frames.
- **Underrun:** src0 drops valid at beat 5 while `m_tready`=1.
  - `o_underrun` pulses once and `o_drop_cnt`=1.
  - Beats 6..10 (tlast) are consumed with `m_tvalid`=0, then IDLE.
- **Clock enable / reset:** `i_clk_en` toggles 1-of-2 during a frame, and `i_reset_n` is asserted mid-frame.
  - With the enable toggling, the frame still transfers intact.
  - After the reset, all readies and valids are 0 and the next grant starts fresh.
